// File: rtl/mig_pkg.sv
// Shared definitions for the majority-inverter evaluation engine: operand code map,
// per-node configuration word layout and controller states.
package mig_pkg;

  localparam int MIG_N_IN    = 7;
  localparam int MIG_N_NODES = 6;
  localparam int MIG_SEL_W   = $clog2(1 + MIG_N_IN + MIG_N_NODES);

  // Operand codes: constant 0, then the primary inputs, then the node outputs.
  localparam int SEL_CONST0 = 0;
  localparam int SEL_X_BASE = 1;
  localparam int SEL_N_BASE = SEL_X_BASE + MIG_N_IN;

  typedef struct packed {
    logic [2:0]           inv;
    logic [MIG_SEL_W-1:0] sel_c;
    logic [MIG_SEL_W-1:0] sel_b;
    logic [MIG_SEL_W-1:0] sel_a;
  } node_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mig_eval_engine_if.sv
// Config-write and vector/result handshake bundle of mig_eval_engine.
// slave = engine side, master = harness side.
interface mig_eval_engine_if
  import mig_pkg::*;
#(
  parameter int N_IN    = MIG_N_IN,
  parameter int N_NODES = MIG_N_NODES
);
  localparam int SEL_W  = $clog2(1 + N_IN + N_NODES);
  localparam int CFG_W  = 3 * SEL_W + 3;
  localparam int ADDR_W = $clog2(N_NODES + 1);

  logic              cfg_we;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_addr;
  logic [CFG_W-1:0]  cfg_data;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_x;
  logic              out_valid;
  logic              out_ready;
  logic              out_y;

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, in_valid, in_x, out_ready,
    output cfg_ready, in_ready, out_valid, out_y
  );

  modport master (
    output cfg_we, cfg_addr, cfg_data, in_valid, in_x, out_ready,
    input  cfg_ready, in_ready, out_valid, out_y
  );

endinterface

// File: rtl/mig_maj3.sv
// Three-input majority gate with per-operand complement.
// Inversion is active only when MIG_INV_EN is defined; otherwise inv is ignored.
module mig_maj3 (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic [2:0] inv,
  output logic       y
);
  logic oa, ob, oc;

`ifdef MIG_INV_EN
  assign oa = a ^ inv[0];
  assign ob = b ^ inv[1];
  assign oc = c ^ inv[2];
`else
  logic unused_inv;
  assign unused_inv = ^inv;
  assign oa = a;
  assign ob = b;
  assign oc = c;
`endif

  assign y = (oa & ob) | (oa & oc) | (ob & oc);

endmodule

// File: rtl/mig_eval_engine.sv
// Runtime-programmable majority-inverter network, evaluated one node per cycle in node order.
// Build option MIG_INV_EN enables complemented edges (inv bits) in every node.
module mig_eval_engine
  import mig_pkg::*;
#(
  parameter int N_IN    = MIG_N_IN,
  parameter int N_NODES = MIG_N_NODES
)(
  input logic             clk,
  input logic             rst_n,
  mig_eval_engine_if.slave bus
);
  localparam int SEL_W     = $clog2(1 + N_IN + N_NODES);
  localparam int CFG_W     = 3 * SEL_W + 3;
  localparam int ADDR_W    = $clog2(N_NODES + 1);
  localparam int K_W       = (N_NODES > 1) ? $clog2(N_NODES) : 1;
  localparam int VW        = 1 << SEL_W;
  localparam int SEL_N_LOC = SEL_N_BASE - MIG_N_IN + N_IN;

  localparam logic [ADDR_W-1:0] OUT_ADDR     = ADDR_W'(N_NODES);
  localparam logic [K_W-1:0]    K_LAST       = K_W'(N_NODES - 1);
  localparam logic [SEL_W-1:0]  OUT_NODE_RST = SEL_W'(N_NODES - 1);

  state_t             state_q, state_d;
  logic [K_W-1:0]     k_q;
  logic [N_IN-1:0]    x_q;
  logic [N_NODES-1:0] node_q;
  logic [CFG_W-1:0]   cfg_q [N_NODES];
  logic [SEL_W-1:0]   out_node_q;

  logic [VW-1:0]      opnd_v;
  logic [VW-1:0]      node_v;
  logic [CFG_W-1:0]   cur_cfg;
  logic [SEL_W-1:0]   sel_a, sel_b, sel_c;
  logic [2:0]         cur_inv;
  logic               maj_y;
  logic               accept;
  logic               cfg_wr;

  // Operand bus padded to every encodable code; unused codes read 0.
  always_comb begin
    opnd_v                        = '0;
    opnd_v[SEL_X_BASE +: N_IN]    = x_q;
    opnd_v[SEL_N_LOC +: N_NODES]  = node_q;
    opnd_v[SEL_CONST0]            = 1'b0;
  end

  assign node_v  = VW'(node_q);
  assign cur_cfg = cfg_q[k_q];
  assign sel_a   = cur_cfg[SEL_W-1:0];
  assign sel_b   = cur_cfg[2*SEL_W-1:SEL_W];
  assign sel_c   = cur_cfg[3*SEL_W-1:2*SEL_W];
  assign cur_inv = cur_cfg[CFG_W-1:3*SEL_W];

  mig_maj3 u_maj (
    .a   (opnd_v[sel_a]),
    .b   (opnd_v[sel_b]),
    .c   (opnd_v[sel_c]),
    .inv (cur_inv),
    .y   (maj_y)
  );

  assign accept = (state_q == ST_IDLE) && bus.in_valid;
  assign cfg_wr = (state_q == ST_IDLE) && bus.cfg_we;

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.cfg_ready = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_y     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.in_ready  = 1'b1;
        bus.cfg_ready = 1'b1;
        if (bus.in_valid) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (k_q == K_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        bus.out_y     = node_v[out_node_q];
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      x_q        <= '0;
      node_q     <= '0;
      out_node_q <= OUT_NODE_RST;
      for (int i = 0; i < N_NODES; i++) cfg_q[i] <= '0;
    end else begin
      state_q <= state_d;
      // A config write in the accept cycle lands before node 0 is first read.
      if (cfg_wr) begin
        if (bus.cfg_addr == OUT_ADDR)
          out_node_q <= bus.cfg_data[SEL_W-1:0];
        else if (bus.cfg_addr < OUT_ADDR)
          cfg_q[bus.cfg_addr] <= bus.cfg_data;
      end
      if (accept) begin
        x_q    <= bus.in_x;
        node_q <= '0;
        k_q    <= '0;
      end else if (state_q == ST_EVAL) begin
        node_q[k_q] <= maj_y;
        k_q         <= k_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mig_eval_engine.sv
// Directed-vector bench for mig_eval_engine; a monitor checks results and latency from a scoreboard.
module tb_mig_eval_engine;
  import mig_pkg::*;

  localparam int N_IN    = 7;
  localparam int N_NODES = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mig_eval_engine_if #(.N_IN(N_IN), .N_NODES(N_NODES)) bus ();

  mig_eval_engine #(.N_IN(N_IN), .N_NODES(N_NODES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic  y;
    int    c;
    string name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc++;

  function automatic node_cfg_t mk(input int a, input int b, input int c, input logic [2:0] inv);
    node_cfg_t r;
    r.inv   = inv;
    r.sel_a = MIG_SEL_W'(a);
    r.sel_b = MIG_SEL_W'(b);
    r.sel_c = MIG_SEL_W'(c);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: first out_valid of a transaction checks latency, handshake checks the result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && !prev_v) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out_valid: got out_valid=1 expected no result pending");
        end else if (cyc - sb[0].c != 7) begin
          errors++;
          $display("FAIL latency_%s: got %0d cycles expected 7", sb[0].name, cyc - sb[0].c);
        end
      end
      if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
        mon_e = sb.pop_front();
        checks++;
        if (bus.out_y !== mon_e.y) begin
          errors++;
          $display("FAIL %s: got out_y=%0b expected %0b", mon_e.name, bus.out_y, mon_e.y);
        end
      end
    end
    prev_v = bus.out_valid;
  end

  task automatic cfg_write(input logic [2:0] addr, input logic [14:0] data);
    @(posedge clk); #1;
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    @(posedge clk); #1;
    bus.cfg_we   = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got %0d results pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_in_ready(input string name);
    int n = 0;
    @(posedge clk); #1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout_%s: got in_ready=0 expected 1", name);
    end
  endtask

  task automatic run_vec(input logic [6:0] x, input logic y, input string name);
    wait_in_ready(name);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    sb.push_back('{y, cyc, name});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_done(name);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic exp_or;
    int   n;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_y",     32'(bus.out_y),     32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    rst_n = 1'b1;
    run_vec(7'h7F, 1'b0, "rst_cfg_zero");

    // Two-input AND from one node
    cfg_write(3'd0, mk(1, 2, 0, 3'b000));
    cfg_write(3'd6, 15'd0);
    run_vec(7'b0000011, 1'b1, "and_11");
    run_vec(7'b0000001, 1'b0, "and_01");

    // Inverted constant operand turns the node into OR
`ifdef MIG_INV_EN
    exp_or = 1'b1;
`else
    exp_or = 1'b0;
`endif
    cfg_write(3'd0, mk(1, 2, 0, 3'b100));
    run_vec(7'b0000001, exp_or, "inv_or_01");
    run_vec(7'b0000011, 1'b1,   "inv_or_11");
    run_vec(7'b0000000, 1'b0,   "inv_or_00");

    // Output node beyond the network reads 0
    cfg_write(3'd6, 15'd7);
    run_vec(7'b0000011, 1'b0, "out_node_oob");

    // Six-node chain
    cfg_write(3'd0, mk(1, 3, 5, 3'b000));
    cfg_write(3'd1, mk(1, 3, 7, 3'b000));
    cfg_write(3'd2, mk(1, 4, 8, 3'b000));
    cfg_write(3'd3, mk(4, 6, 9, 3'b000));
    cfg_write(3'd4, mk(2, 8, 11, 3'b000));
    cfg_write(3'd5, mk(2, 10, 12, 3'b000));
    cfg_write(3'd6, 15'd5);
    run_vec(7'h00,       1'b0, "chain_00");
    run_vec(7'h7F,       1'b1, "chain_7f");
    run_vec(7'b0001101,  1'b1, "chain_0d");
    run_vec(7'b0100010,  1'b0, "chain_22");

    // Backpressure: result held, inputs and config blocked
    bus.out_ready = 1'b0;
    wait_in_ready("bp");
    bus.in_valid = 1'b1;
    bus.in_x     = 7'h7F;
    sb.push_back('{1'b1, cyc, "bp_result"});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.cfg_we   = (i == 0);
      bus.cfg_addr = 3'd6;
      bus.cfg_data = 15'd7;
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_y",     32'(bus.out_y),     32'd1);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      chk("bp_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.cfg_we    = 1'b0;
    bus.out_ready = 1'b1;
    wait_done("bp_result");
    run_vec(7'b0001101, 1'b1, "bp_cfg_ignored");

    // Forward references read the cleared value
    cfg_write(3'd0, mk(9, 1, 1, 3'b000));
    cfg_write(3'd6, 15'd0);
    run_vec(7'h01, 1'b1, "fwd_ref_n1");
    cfg_write(3'd0, mk(10, 0, 1, 3'b000));
    run_vec(7'h01, 1'b0, "fwd_ref_n2");

    // Config write in the same cycle as the vector is used by that vector
    wait_in_ready("cfg_same_cycle");
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 3'd0;
    bus.cfg_data = mk(1, 2, 0, 3'b000);
    bus.in_valid = 1'b1;
    bus.in_x     = 7'b0000011;
    sb.push_back('{1'b1, cyc, "cfg_same_cycle"});
    @(posedge clk); #1;
    bus.cfg_we   = 1'b0;
    bus.in_valid = 1'b0;
    wait_done("cfg_same_cycle");

    // Reset mid-evaluation abandons the vector and clears config
    wait_in_ready("rst_mid");
    bus.in_valid = 1'b1;
    bus.in_x     = 7'b0000011;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mid_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (12) @(negedge clk);
    run_vec(7'h7F, 1'b0, "rst_mid_cfg_cleared");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
